// File: rtl/dma_lite_seq.sv
// dma_lite_seq: sequences one AXI DMA simple-mode transfer over AXI-Lite.
// Define DMA_IOC_CLEAR_EN to W1C the IOC status bits before done.
module dma_lite_seq #(
  parameter int LEN_W    = 26,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] xfer_len,
  output logic             busy,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [31:0]      last_status,
  output logic [9:0]       lite_awaddr,
  output logic [31:0]      lite_wdata,
  output logic             lite_valid,
  input  logic             lite_end,
  output logic [9:0]       lite_araddr,
  output logic             lite_rvalid_req,
  input  logic             lite_rend,
  input  logic [31:0]      lite_rdata
);
  localparam int PW = $clog2(POLL_MAX + 1);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    IDLE, WRITE, POLL_S2MM, POLL_MM2S, GAP, CLEAR, DONE
  } state_t;

  state_t           state, state_d;
  logic [2:0]       step, step_d;
  logic [PW-1:0]    poll_cnt, poll_cnt_d, poll_inc;
  logic [GW-1:0]    gap_cnt, gap_cnt_d;
  logic             req, req_d;
  logic             gap_mm2s, gap_mm2s_d;
  logic [31:0]      src, src_d, dst, dst_d;
  logic [31:0]      status, status_d;
  logic [LEN_W-1:0] len, len_d;
  logic [1:0]       err, err_d;
  logic [31:0]      len_ext;
  logic             wr_st, rd_st;

  assign len_ext  = 32'(len);
  assign poll_inc = poll_cnt + 1'b1;
  assign wr_st    = (state == WRITE) || (state == CLEAR);
  assign rd_st    = (state == POLL_S2MM) || (state == POLL_MM2S);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      step     <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
      req      <= 1'b0;
      gap_mm2s <= 1'b0;
      src      <= '0;
      dst      <= '0;
      len      <= '0;
      status   <= '0;
      err      <= '0;
    end else begin
      state    <= state_d;
      step     <= step_d;
      poll_cnt <= poll_cnt_d;
      gap_cnt  <= gap_cnt_d;
      req      <= req_d;
      gap_mm2s <= gap_mm2s_d;
      src      <= src_d;
      dst      <= dst_d;
      len      <= len_d;
      status   <= status_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d    = state;
    step_d     = step;
    poll_cnt_d = poll_cnt;
    gap_cnt_d  = gap_cnt;
    req_d      = req;
    gap_mm2s_d = gap_mm2s;
    src_d      = src;
    dst_d      = dst;
    len_d      = len;
    status_d   = status;
    err_d      = err;
    case (state)
      IDLE: begin
        if (start) begin
          src_d      = src_addr;
          dst_d      = dst_addr;
          len_d      = xfer_len;
          err_d      = 2'd0;
          step_d     = '0;
          req_d      = 1'b0;
          poll_cnt_d = '0;
          if (xfer_len == '0) begin
            state_d = DONE;
            err_d   = 2'd1;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WRITE, CLEAR: begin
        if (!req) begin
          req_d = 1'b1;
        end else if (lite_end) begin
          req_d  = 1'b0;
          step_d = step + 3'd1;
          if (state == WRITE && step == 3'd5) begin
            state_d    = POLL_S2MM;
            step_d     = '0;
            poll_cnt_d = '0;
          end else if (state == CLEAR && step == 3'd1) begin
            state_d = DONE;
            err_d   = 2'd0;
          end
        end
      end
      POLL_S2MM, POLL_MM2S: begin
        if (!req) begin
          req_d = 1'b1;
        end else if (lite_rend) begin
          req_d    = 1'b0;
          status_d = lite_rdata;
          if (lite_rdata[6:4] != 3'b000) begin
            state_d = DONE;
            err_d   = 2'd2;
          end else if (lite_rdata[1]) begin
            poll_cnt_d = '0;
            if (state == POLL_S2MM) begin
              state_d = POLL_MM2S;
            end else begin
`ifdef DMA_IOC_CLEAR_EN
              state_d = CLEAR;
              step_d  = '0;
`else
              state_d = DONE;
              err_d   = 2'd0;
`endif
            end
          end else if (poll_inc == PW'(POLL_MAX)) begin
            state_d = DONE;
            err_d   = 2'd3;
          end else begin
            poll_cnt_d = poll_inc;
            gap_cnt_d  = '0;
            gap_mm2s_d = (state == POLL_MM2S);
            state_d    = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GW'(POLL_GAP - 1)) begin
          state_d = gap_mm2s ? POLL_MM2S : POLL_S2MM;
        end else begin
          gap_cnt_d = gap_cnt + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // register writes: MM2S/S2MM run bits, then addresses and lengths
  always_comb begin
    lite_awaddr = '0;
    lite_wdata  = '0;
    if (state == WRITE) begin
      case (step)
        3'd0: begin lite_awaddr = 10'h000; lite_wdata = 32'h1; end
        3'd1: begin lite_awaddr = 10'h030; lite_wdata = 32'h1; end
        3'd2: begin lite_awaddr = 10'h048; lite_wdata = dst; end
        3'd3: begin lite_awaddr = 10'h058; lite_wdata = len_ext; end
        3'd4: begin lite_awaddr = 10'h018; lite_wdata = src; end
        default: begin
          lite_awaddr = 10'h028;
          lite_wdata  = len_ext;
        end
      endcase
    end else if (state == CLEAR) begin
      lite_awaddr = step[0] ? 10'h004 : 10'h034;
      lite_wdata  = 32'h0000_1000;
    end
  end

  assign lite_araddr = (state == POLL_MM2S) ? 10'h004 :
                       (state == POLL_S2MM) ? 10'h034 : 10'h000;

  // requests drop in the reset cycle itself, not one cycle later
  assign lite_valid      = req & wr_st & ~rst;
  assign lite_rvalid_req = req & rd_st & ~rst;

  assign busy        = (state != IDLE) && (state != DONE);
  assign done        = (state == DONE);
  assign err_code    = err;
  assign last_status = status;
endmodule

// File: tb/tb_dma_lite_seq.sv
// tb_dma_lite_seq: scoreboard bench for dma_lite_seq with random
// responders and a transaction-level reference model.
module tb_dma_lite_seq;
  localparam int LEN_W    = 26;
  localparam int POLL_GAP = 5;
  localparam int POLL_MAX = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      src_addr = '0;
  logic [31:0]      dst_addr = '0;
  logic [LEN_W-1:0] xfer_len = '0;
  logic             busy, done;
  logic [1:0]       err_code;
  logic [31:0]      last_status;
  logic [9:0]       lite_awaddr, lite_araddr;
  logic [31:0]      lite_wdata;
  logic             lite_valid, lite_rvalid_req;
  logic             lite_end = 1'b0;
  logic             lite_rend = 1'b0;
  logic [31:0]      lite_rdata = '0;

  dma_lite_seq #(
    .LEN_W(LEN_W), .POLL_GAP(POLL_GAP), .POLL_MAX(POLL_MAX)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr),
    .xfer_len(xfer_len), .busy(busy), .done(done),
    .err_code(err_code), .last_status(last_status),
    .lite_awaddr(lite_awaddr), .lite_wdata(lite_wdata),
    .lite_valid(lite_valid), .lite_end(lite_end),
    .lite_araddr(lite_araddr),
    .lite_rvalid_req(lite_rvalid_req),
    .lite_rend(lite_rend), .lite_rdata(lite_rdata)
  );

  always #5 clk = ~clk;

  logic [43:0] exp_q[$];
  logic [31:0] s2mm_q[$];
  logic [31:0] mm2s_q[$];
  logic [31:0] model_last = '0;
  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int wlat = 0;
  int rlat = 0;

  function automatic logic [43:0] ev(int k, logic [9:0] a,
                                     logic [31:0] d);
    logic [1:0] kk;
    kk = k[1:0];
    return {kk, a, d};
  endfunction

  function automatic void push(int k, logic [9:0] a, logic [31:0] d);
    exp_q.push_back(ev(k, a, d));
  endfunction

  task automatic check(string name, logic [63:0] act,
                       logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(int k, logic [9:0] a, logic [31:0] d);
    logic [43:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %h expected none",
               ev(k, a, d));
    end else begin
      e = exp_q.pop_front();
      if (ev(k, a, d) !== e) begin
        errors++;
        $display("FAIL event: got %h expected %h", ev(k, a, d), e);
      end
    end
  endtask

  // one channel's polling outcome: 0 idle, 2 DMA error, 3 timeout
  function automatic int poll(logic [9:0] a, logic [31:0] st[$]);
    logic [31:0] v;
    for (int i = 0; i < POLL_MAX; i++) begin
      v = (i < st.size()) ? st[i] : 32'h0;
      push(1, a, 32'h0);
      model_last = v;
      if (v[6:4] != 3'b000) return 2;
      if (v[1]) return 1 - 1;
    end
    return 3;
  endfunction

  function automatic void model(logic [31:0] s, logic [31:0] d,
                                logic [LEN_W-1:0] l);
    int e;
    if (l == '0) begin
      push(2, 10'd1, model_last);
      return;
    end
    push(0, 10'h000, 32'h1);
    push(0, 10'h030, 32'h1);
    push(0, 10'h048, d);
    push(0, 10'h058, 32'(l));
    push(0, 10'h018, s);
    push(0, 10'h028, 32'(l));
    e = poll(10'h034, s2mm_q);
    if (e == 0) e = poll(10'h004, mm2s_q);
`ifdef DMA_IOC_CLEAR_EN
    if (e == 0) begin
      push(0, 10'h034, 32'h1000);
      push(0, 10'h004, 32'h1000);
    end
`endif
    push(2, 10'(e), model_last);
  endfunction

  // write responder
  initial begin
    int c = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || lite_end) begin
        lite_end = 1'b0;
        c = 0;
      end else if (lite_valid) begin
        if (c >= wlat) begin lite_end = 1'b1; c = 0; end
        else c++;
      end
    end
  end

  // read responder; an empty status list reads as busy (0)
  initial begin
    int c = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || lite_rend) begin
        lite_rend = 1'b0;
        c = 0;
      end else if (lite_rvalid_req) begin
        if (c >= rlat) begin
          lite_rend = 1'b1;
          c = 0;
          if (lite_araddr == 10'h034)
            lite_rdata = s2mm_q.size() ? s2mm_q.pop_front() : 32'h0;
          else
            lite_rdata = mm2s_q.size() ? mm2s_q.pop_front() : 32'h0;
        end else c++;
      end
    end
  end

  // monitor
  initial begin
    logic prev_rreq;
    logic [9:0] last_ra;
    bit have_rd;
    int gap;
    prev_rreq = 1'b0;
    last_ra = '0;
    have_rd = 0;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        have_rd = 0;
        prev_rreq = 1'b0;
      end else begin
        if (lite_valid && lite_rvalid_req)
          check("both_requests", 1, 0);
        if (lite_valid && lite_end) begin
          wr_seen++;
          observe(0, lite_awaddr, lite_wdata);
        end
        if (lite_rvalid_req && !prev_rreq && have_rd &&
            lite_araddr == last_ra)
          check("poll_gap_ok", gap >= POLL_GAP, 1);
        if (lite_rvalid_req && lite_rend) begin
          observe(1, lite_araddr, 32'h0);
          have_rd = 1;
          last_ra = lite_araddr;
          gap = 0;
        end else if (!lite_rvalid_req) begin
          gap++;
        end
        if (done) begin
          done_seen++;
          check("busy_at_done", busy, 0);
          observe(2, {8'h0, err_code}, last_status);
          have_rd = 0;
        end
        prev_rreq = lite_rvalid_req;
      end
    end
  end

  task automatic drive_start(logic [31:0] s, logic [31:0] d,
                             logic [LEN_W-1:0] l);
    @(posedge clk); #1;
    src_addr = s;
    dst_addr = d;
    xfer_len = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run(logic [31:0] s, logic [31:0] d,
                     logic [LEN_W-1:0] l, output int lat);
    model(s, d, l);
    drive_start(s, d, l);
    if (l != '0) check("busy_after_start", busy, 1);
    lat = 0;
    while (!done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    check("done_seen", done, 1);
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    exp_q.delete();
    s2mm_q.delete();
    mm2s_q.delete();
  endtask

  function automatic void gen_status(bit s2mm);
    logic [31:0] q[$];
    logic [31:0] w;
    int nb;
    nb = $urandom_range(0, 4);
    for (int i = 0; i < nb; i++) begin
      w = $urandom;
      w[6:4] = 3'b000;
      w[1] = 1'b0;
      q.push_back(w);
    end
    w = $urandom;
    w[6:4] = 3'b000;
    if ($urandom_range(0, 7) == 0) w[4 + $urandom_range(0, 2)] = 1'b1;
    else w[1] = 1'b1;
    q.push_back(w);
    if (s2mm) s2mm_q = q;
    else mm2s_q = q;
  endfunction

  initial begin
    int lat, base, n, d0;
    logic [LEN_W-1:0] l;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs",
          {busy, done, err_code, last_status, lite_awaddr, lite_wdata,
           lite_valid, lite_araddr, lite_rvalid_req}, '0);

    // nominal directed transfer
    wlat = 3;
    rlat = 3;
    s2mm_q = '{32'h0, 32'h2};
    mm2s_q = '{32'h2};
    run(32'h1000_0000, 32'h2000_0000, LEN_W'(32'h100), lat);

    // zero length
    run(32'h1, 32'h2, '0, lat);
    check("zero_len_latency", lat <= 2, 1);

    // S2MM error
    wlat = 1;
    rlat = 0;
    s2mm_q = '{32'h10};
    mm2s_q = '{32'h2};
    run(32'hA0, 32'hB0, LEN_W'(32'h40), lat);

    // S2MM timeout
    rlat = 2;
    run(32'hC0, 32'hD0, LEN_W'(32'h80), lat);

    // second start ignored, then reset during step 3
    wlat = 2;
    s2mm_q = '{32'h2};
    mm2s_q = '{32'h2};
    model(32'h5000, 32'h6000, LEN_W'(32'h200));
    base = wr_seen;
    drive_start(32'h5000, 32'h6000, LEN_W'(32'h200));
    n = 0;
    while (wr_seen < base + 1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    drive_start(32'h7000, 32'h8000, LEN_W'(32'h300));
    n = 0;
    while (wr_seen < base + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("reached_step3", wr_seen >= base + 3, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("valid_drop_in_rst", {lite_valid, lite_rvalid_req}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("outputs_after_rst",
          {busy, done, err_code, last_status, lite_awaddr, lite_wdata,
           lite_valid, lite_araddr, lite_rvalid_req}, '0);
    model_last = '0;
    exp_q.delete();
    s2mm_q.delete();
    mm2s_q.delete();
    d0 = done_seen;
    repeat (20) @(posedge clk);
    #1;
    check("no_done_after_rst", done_seen, d0);

    // restart from step 0
    s2mm_q = '{32'h0, 32'h0, 32'h2};
    mm2s_q = '{32'h0, 32'h2};
    run(32'h9000, 32'hA000, LEN_W'(32'h1234), lat);

    // randomized transfers
    for (int t = 0; t < 25; t++) begin
      wlat = $urandom_range(0, 3);
      rlat = $urandom_range(0, 3);
      gen_status(1);
      gen_status(0);
      l = ($urandom_range(0, 5) == 0) ? '0 : LEN_W'($urandom);
      run($urandom, $urandom, l, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dma_lite_seq.md
Name: dma_lite_seq

Overview:
- Sequences one AXI DMA simple-mode transfer (MM2S + S2MM) over the shared AXI-Lite register path.
- Latches src/dst/length on start and issues six register writes through the lite write request port (the AXI-Lite write master).
- Polls the S2MM then MM2S status registers through a lite read request port until both channels are idle, then reports done/error.

Parameters:
- LEN_W, 26, width of the transfer length in bytes (DMA LENGTH register width).
- POLL_GAP, 16, idle clk cycles between consecutive status reads (≥1).
- POLL_MAX, 4096, maximum status reads per channel before timeout (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle transfer request
- src_addr  in  32  MM2S source byte address
- dst_addr  in  32  S2MM destination byte address
- xfer_len  in  LEN_W  transfer length in bytes
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- err_code  out  2  0 ok, 1 zero length, 2 DMA error, 3 timeout; valid when done=1
- last_status  out  32  last DMASR value read
- lite_awaddr  out  10  write register offset
- lite_wdata  out  32  write data
- lite_valid  out  1  write request
- lite_end  in  1  write complete pulse
- lite_araddr  out  10  read register offset
- lite_rvalid_req  out  1  read request
- lite_rend  in  1  read complete pulse
- lite_rdata  in  32  read data, valid with lite_rend

Behaviour:
- Reset: all outputs 0, state IDLE, step/poll/gap counters 0.
- Request handshake (both ports): valid rises with addr/data stable, held until the matching end pulse, deasserts the cycle after the end pulse. One request is outstanding at a time. An end pulse without valid is ignored.
- IDLE: on start, latch src/dst/len and set busy next cycle. If len==0, go to DONE with err_code=1 and no bus traffic. start while busy is ignored.
- WRITE step k=0..5, fixed order (offset, data):
  - 0x000 ← 0x0000_0001
  - 0x030 ← 0x0000_0001
  - 0x048 ← dst
  - 0x058 ← {zero-pad, len}
  - 0x018 ← src
  - 0x028 ← {zero-pad, len}
  - After each lite_end, advance k. After k=5, go to POLL_S2MM.
- POLL_S2MM: read 0x034.
  - On lite_rend, capture last_status.
  - If bits[6:4]≠0, go to DONE with err=2.
  - Else if bit1 (Idle)=1, go to POLL_MM2S.
  - Else increment the poll count; if count==POLL_MAX, go to DONE with err=3; otherwise wait POLL_GAP cycles in GAP and reissue.
- POLL_MM2S: identical procedure at offset 0x004, with its own poll count reset to 0. On success, go to CLEAR (feature on) or DONE with err=0.
- DONE: done=1 for one cycle and busy=0 in the same cycle. err_code holds until the next start. Return to IDLE.
- Minimum latency (zero-gap responders): six writes plus two reads, each taking request + end + drop cycles.
- Reset mid-operation: return to IDLE the next cycle and drop valid immediately. No done pulse. The downstream controller shares rst.

Optional Feature:
- DMA_IOC_CLEAR_EN:
  - Defined: after successful polling, write 0x0000_1000 to 0x034, then to 0x004 (W1C IOC), before done. An error or timeout skips this clear. Latency +2 writes.
  - Undefined: the IOC bits are left set and the path goes directly to DONE.

Test Plan:
- start src=0x1000_0000, dst=0x2000_0000, len=0x100; both responders end after 3 cycles; statuses 0x0 then 0x2 → six writes in exact order/data, two S2MM reads, one MM2S read, done with err=0, last_status=0x0000_0002.
- start with len=0 → done within 2 cycles, err=1, lite_valid and lite_rvalid_req never asserted.
- S2MM status returns 0x0000_0010 → done with err=2, last_status=0x10, no MM2S read.
- S2MM status stuck at 0x0 with POLL_MAX=4 → exactly 4 reads spaced ≥POLL_GAP cycles, then done with err=3.
- Second start pulse mid-write plus rst asserted during step 3 → the second start is ignored; after rst all outputs are 0 next cycle and there is no done pulse; a new start restarts from step 0.
- DMA_IOC_CLEAR_EN defined, nominal run → writes 0x1000 to 0x034 and then 0x004 before done, err=0.
